// File: rtl/miriscv_mem_pkg.sv
// Shared definitions for the unified instruction/data memory path.
//   owner_e        : which requester owns the response currently in flight
//   BE_WORD        : all-ones byte-enable pattern (sliced to DATA_W/8 by users)
//   MAX_STARVE_DEF : default number of conflicts data may win in a row
package miriscv_mem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  // Wide enough for any DATA_W up to 512; users take the low DATA_W/8 bits.
  localparam logic [63:0] BE_WORD = '1;

  localparam int MAX_STARVE_DEF = 3;

endpackage

// File: rtl/miriscv_imem_arbiter_if.sv
// Bundle of the fetch, LSU and memory-port signals around the arbiter.
//   slave  : arbiter view (requests and mem_rdata_i in, grants/responses/mem_* out)
//   master : environment view (core requesters plus the RAM)
interface miriscv_imem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                instr_req_i;
  logic [ADDR_W-1:0]   instr_addr_i;
  logic                instr_gnt_o;
  logic                instr_rvalid_o;
  logic [DATA_W-1:0]   instr_rdata_o;

  logic                data_req_i;
  logic                data_we_i;
  logic [DATA_W/8-1:0] data_be_i;
  logic [ADDR_W-1:0]   data_addr_i;
  logic [DATA_W-1:0]   data_wdata_i;
  logic                data_gnt_o;
  logic                data_rvalid_o;
  logic [DATA_W-1:0]   data_rdata_o;

  logic                mem_req_o;
  logic                mem_we_o;
  logic [DATA_W/8-1:0] mem_be_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [DATA_W-1:0]   mem_wdata_o;
  logic [DATA_W-1:0]   mem_rdata_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  mem_rdata_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output mem_rdata_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  data_gnt_o, data_rvalid_o, data_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/miriscv_imem_arbiter.sv
// Arbiter sharing one fixed-latency (1 cycle) single-port RAM between the
// instruction fetch unit and the LSU. Data wins conflicts until it has won
// MAX_STARVE in a row, then fetch is forced through. Grants are combinational;
// an owner FSM steers the next-cycle read data back to the right requester.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous reset, active-low
//   bus : fetch / LSU / memory signals (slave modport)
module miriscv_imem_arbiter
  import miriscv_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STARVE = MAX_STARVE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  miriscv_imem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_STARVE + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STARVE);

  owner_e              state;
  owner_e              state_nxt;
  logic [CNT_W-1:0]    starve_cnt;
  logic [CNT_W-1:0]    starve_nxt;
  logic                conflict;
  logic                instr_gnt;
  logic                data_gnt;
  logic                instr_rvalid;
  logic                data_rvalid;
  logic                we_sel;
  logic [DATA_W/8-1:0] be_sel;
  logic [ADDR_W-1:0]   addr_sel;
  logic [DATA_W-1:0]   wdata_sel;

  assign conflict = bus.instr_req_i && bus.data_req_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Grant selection, owner next-state and response valids.
  always_comb begin
    instr_gnt    = 1'b0;
    data_gnt     = 1'b0;
    state_nxt    = OWN_NONE;
    instr_rvalid = 1'b0;
    data_rvalid  = 1'b0;
    if (rst) begin
      if (conflict) begin
        if (starve_cnt < MAX_CNT) data_gnt  = 1'b1;
        else                      instr_gnt = 1'b1;
      end else begin
        instr_gnt = bus.instr_req_i;
        data_gnt  = bus.data_req_i;
      end
      // Gating with rst drops a response that was in flight when reset hit.
      instr_rvalid = (state == OWN_INSTR);
      data_rvalid  = (state == OWN_DATA);
    end
    if (instr_gnt)     state_nxt = OWN_INSTR;
    else if (data_gnt) state_nxt = OWN_DATA;
  end

  // Only a data win over a waiting fetch counts as starvation.
  always_comb begin
    starve_nxt = starve_cnt;
    if (instr_gnt) begin
      starve_nxt = '0;
    end else if (data_gnt && conflict && (starve_cnt != MAX_CNT)) begin
      starve_nxt = starve_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    we_sel    = 1'b0;
    be_sel    = '0;
    addr_sel  = '0;
    wdata_sel = '0;
    if (instr_gnt) begin
      be_sel   = BE_WORD[DATA_W/8-1:0];
      addr_sel = bus.instr_addr_i;
    end else if (data_gnt) begin
      we_sel    = bus.data_we_i;
      be_sel    = bus.data_be_i;
      addr_sel  = bus.data_addr_i;
      wdata_sel = bus.data_wdata_i;
    end
  end

  assign bus.instr_gnt_o    = instr_gnt;
  assign bus.data_gnt_o     = data_gnt;
  assign bus.mem_req_o      = instr_gnt || data_gnt;
  assign bus.mem_we_o       = we_sel;
  assign bus.mem_be_o       = be_sel;
  assign bus.mem_addr_o     = addr_sel;
  assign bus.mem_wdata_o    = wdata_sel;
  assign bus.instr_rvalid_o = instr_rvalid;
  assign bus.data_rvalid_o  = data_rvalid;
  assign bus.instr_rdata_o  = instr_rvalid ? bus.mem_rdata_i : '0;
  assign bus.data_rdata_o   = data_rvalid  ? bus.mem_rdata_i : '0;

endmodule

// File: tb/tb_miriscv_imem_arbiter.sv
// Bench for miriscv_imem_arbiter: directed vector table, a hand-written
// reset-while-fetch-in-flight sequence, then random traffic against a
// transaction-level reference model.
module tb_miriscv_imem_arbiter;
  import miriscv_mem_pkg::*;

  localparam int MAXS = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  miriscv_imem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  miriscv_imem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STARVE(MAXS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] mrdata;
    logic        e_ig;
    logic        e_dg;
    logic        e_irv;
    logic        e_drv;
    int          e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic ireq, input logic [31:0] iaddr,
                       input logic dreq, input logic dwe, input logic [3:0] dbe,
                       input logic [31:0] daddr, input logic [31:0] dwdata,
                       input logic [31:0] mrdata);
    rst              = r;
    bus.instr_req_i  = ireq;
    bus.instr_addr_i = iaddr;
    bus.data_req_i   = dreq;
    bus.data_we_i    = dwe;
    bus.data_be_i    = dbe;
    bus.data_addr_i  = daddr;
    bus.data_wdata_i = dwdata;
    bus.mem_rdata_i  = mrdata;
  endtask

  // Compares every combinational output against the expected grant/response
  // pattern; the memory-port fields follow from which side was granted.
  task automatic check_outputs(input string name, input logic e_ig, input logic e_dg,
                               input logic e_irv, input logic e_drv);
    logic        ewe;
    logic [3:0]  ebe;
    logic [31:0] eaddr;
    logic [31:0] ewd;
    ewe = 1'b0; ebe = 4'h0; eaddr = 32'h0; ewd = 32'h0;
    if (e_ig) begin
      ebe = 4'hF; eaddr = bus.instr_addr_i;
    end else if (e_dg) begin
      ewe = bus.data_we_i; ebe = bus.data_be_i; eaddr = bus.data_addr_i; ewd = bus.data_wdata_i;
    end
    chk({name, ".instr_gnt"},    32'(bus.instr_gnt_o),    32'(e_ig));
    chk({name, ".data_gnt"},     32'(bus.data_gnt_o),     32'(e_dg));
    chk({name, ".instr_rvalid"}, 32'(bus.instr_rvalid_o), 32'(e_irv));
    chk({name, ".data_rvalid"},  32'(bus.data_rvalid_o),  32'(e_drv));
    chk({name, ".instr_rdata"},  bus.instr_rdata_o, e_irv ? bus.mem_rdata_i : 32'h0);
    chk({name, ".data_rdata"},   bus.data_rdata_o,  e_drv ? bus.mem_rdata_i : 32'h0);
    chk({name, ".mem_req"},      32'(bus.mem_req_o),      32'(e_ig || e_dg));
    chk({name, ".mem_we"},       32'(bus.mem_we_o),       32'(ewe));
    chk({name, ".mem_be"},       32'(bus.mem_be_o),       32'(ebe));
    chk({name, ".mem_addr"},     bus.mem_addr_o,  eaddr);
    chk({name, ".mem_wdata"},    bus.mem_wdata_o, ewd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          mcnt;
    int          prev_owner;
    logic        ireq_act, dreq_act, dwe_r, r, conf, m_ig, m_dg;
    logic [31:0] iaddr_r, daddr_r, dwd_r, mrd;
    logic [3:0]  dbe_r;

    //            name    rst ireq iaddr     dreq we be    daddr     wdata         mrdata      ig dg irv drv cnt
    vecs.push_back('{"rst",  0, 1, 32'h0,   1, 0, 4'hF, 32'h200, 32'h0,        32'h77,     0, 0, 0, 0, 0});
    vecs.push_back('{"f0",   1, 1, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,        32'h0,      1, 0, 0, 0, 0});
    vecs.push_back('{"f1",   1, 1, 32'h4,   0, 0, 4'h0, 32'h0,   32'h0,        32'h13,     1, 0, 1, 0, 0});
    vecs.push_back('{"f2",   1, 1, 32'h8,   0, 0, 4'h0, 32'h0,   32'h0,        32'h93,     1, 0, 1, 0, 0});
    vecs.push_back('{"f3",   1, 0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,        32'h113,    0, 0, 1, 0, 0});
    vecs.push_back('{"dw",   1, 0, 32'h0,   1, 1, 4'h3, 32'h40,  32'hDEADBEEF, 32'h0,      0, 1, 0, 0, 0});
    vecs.push_back('{"dwr",  1, 0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,        32'h55,     0, 0, 0, 1, 0});
    vecs.push_back('{"c0",   1, 1, 32'h100, 1, 0, 4'hF, 32'h200, 32'hCAFE0000, 32'h1000,   0, 1, 0, 0, 1});
    vecs.push_back('{"c1",   1, 1, 32'h100, 1, 0, 4'hF, 32'h200, 32'hCAFE0000, 32'h1001,   0, 1, 0, 1, 2});
    vecs.push_back('{"c2",   1, 1, 32'h100, 1, 0, 4'hF, 32'h200, 32'hCAFE0000, 32'h1002,   0, 1, 0, 1, 3});
    vecs.push_back('{"c3",   1, 1, 32'h100, 1, 0, 4'hF, 32'h200, 32'hCAFE0000, 32'h1003,   1, 0, 0, 1, 0});
    vecs.push_back('{"c4",   1, 1, 32'h100, 1, 0, 4'hF, 32'h200, 32'hCAFE0000, 32'h1004,   0, 1, 1, 0, 1});
    vecs.push_back('{"c5",   1, 1, 32'h100, 1, 0, 4'hF, 32'h200, 32'hCAFE0000, 32'h1005,   0, 1, 0, 1, 2});
    vecs.push_back('{"c6",   1, 1, 32'h100, 1, 0, 4'hF, 32'h200, 32'hCAFE0000, 32'h1006,   0, 1, 0, 1, 3});
    vecs.push_back('{"c7",   1, 1, 32'h100, 1, 0, 4'hF, 32'h200, 32'hCAFE0000, 32'h1007,   1, 0, 0, 1, 0});
    vecs.push_back('{"cend", 1, 0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,        32'h2000,   0, 0, 1, 0, 0});
    vecs.push_back('{"a0",   1, 1, 32'h10,  0, 0, 4'h0, 32'h0,   32'h0,        32'h0,      1, 0, 0, 0, 0});
    vecs.push_back('{"a1",   1, 0, 32'h0,   1, 0, 4'hF, 32'h80,  32'h0,        32'h3000,   0, 1, 1, 0, 0});
    vecs.push_back('{"a2",   1, 0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,        32'h3001,   0, 0, 0, 1, 0});
    vecs.push_back('{"r0",   1, 1, 32'h20,  1, 0, 4'hF, 32'h84,  32'h0,        32'h0,      0, 1, 0, 0, 1});
    vecs.push_back('{"r1",   0, 1, 32'h20,  1, 0, 4'hF, 32'h84,  32'h0,        32'h3002,   0, 0, 0, 0, 0});
    vecs.push_back('{"r2",   1, 0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,        32'h3003,   0, 0, 0, 0, 0});
    vecs.push_back('{"i0",   1, 1, 32'h30,  1, 0, 4'hF, 32'h88,  32'h0,        32'h0,      0, 1, 0, 0, 1});
    vecs.push_back('{"i1",   1, 1, 32'h30,  0, 0, 4'h0, 32'h0,   32'h0,        32'h4000,   1, 0, 0, 1, 0});
    vecs.push_back('{"i2",   1, 0, 32'h0,   1, 0, 4'hF, 32'h8C,  32'h0,        32'h4001,   0, 1, 1, 0, 0});
    vecs.push_back('{"i3",   1, 1, 32'h40,  1, 0, 4'hF, 32'h90,  32'h0,        32'h4002,   0, 1, 0, 1, 1});
    vecs.push_back('{"id0",  1, 1, 32'h40,  0, 0, 4'h0, 32'h0,   32'h0,        32'h4003,   1, 0, 0, 1, 0});
    vecs.push_back('{"id1",  1, 0, 32'h0,   1, 0, 4'hF, 32'h94,  32'h0,        32'h4004,   0, 1, 1, 0, 0});
    vecs.push_back('{"id2",  1, 1, 32'h44,  1, 0, 4'hF, 32'h98,  32'h0,        32'h4005,   0, 1, 0, 1, 1});
    vecs.push_back('{"idl0", 1, 1, 32'h44,  0, 0, 4'h0, 32'h0,   32'h0,        32'h4006,   1, 0, 0, 1, 0});
    vecs.push_back('{"idl1", 1, 0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,        32'h4007,   0, 0, 1, 0, 0});
    vecs.push_back('{"idl2", 1, 0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,        32'h4008,   0, 0, 0, 0, 0});
    vecs.push_back('{"idl3", 1, 0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,        32'h4009,   0, 0, 0, 0, 0});
    vecs.push_back('{"idl4", 1, 0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,        32'h400A,   0, 0, 0, 0, 0});
    // Nonzero count held across idle cycles and a lone data grant.
    vecs.push_back('{"h0",   1, 1, 32'h50,  1, 0, 4'hF, 32'hA0,  32'h0,        32'h0,      0, 1, 0, 0, 1});
    vecs.push_back('{"h1",   1, 0, 32'h50,  0, 0, 4'h0, 32'h0,   32'h0,        32'h5000,   0, 0, 0, 1, 1});
    vecs.push_back('{"h2",   1, 0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,        32'h5001,   0, 0, 0, 0, 1});
    vecs.push_back('{"h3",   1, 0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,        32'h5002,   0, 0, 0, 0, 1});
    vecs.push_back('{"h4",   1, 0, 32'h0,   1, 1, 4'hC, 32'hA4,  32'h12345678, 32'h5003,   0, 1, 0, 0, 1});
    vecs.push_back('{"h5",   1, 1, 32'h54,  0, 0, 4'h0, 32'h0,   32'h0,        32'h5004,   1, 0, 0, 1, 0});
    vecs.push_back('{"h6",   1, 0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,        32'h5005,   0, 0, 1, 0, 0});

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].dwe,
            vecs[i].dbe, vecs[i].daddr, vecs[i].dwdata, vecs[i].mrdata);
      #4;
      check_outputs(vecs[i].name, vecs[i].e_ig, vecs[i].e_dg, vecs[i].e_irv, vecs[i].e_drv);
      @(posedge clk); #1;
      chk({vecs[i].name, ".starve_cnt"}, 32'(dut.starve_cnt), 32'(vecs[i].e_cnt));
    end

    // Fetch in flight when reset asserts: the response must vanish.
    drive(1, 1, 32'h60, 0, 0, 0, 0, 0, 32'h0);
    #4;
    check_outputs("rf_req", 1, 0, 0, 0);
    @(posedge clk); #1;
    chk("rf_req.state", 32'(dut.state), 32'(OWN_INSTR));
    drive(0, 1, 32'h64, 1, 0, 4'hF, 32'hB0, 0, 32'h6000);
    #4;
    check_outputs("rf_rst", 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("rf_rst.state", 32'(dut.state), 32'(OWN_NONE));
    chk("rf_rst.starve_cnt", 32'(dut.starve_cnt), 32'd0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h6001);
    #4;
    check_outputs("rf_after", 0, 0, 0, 0);
    @(posedge clk); #1;

    // Random traffic: requesters hold their request until granted; the model
    // tracks conflict wins and the owner of last cycle's memory access.
    mcnt = 0; prev_owner = 0;
    ireq_act = 0; dreq_act = 0;
    iaddr_r = 0; daddr_r = 0; dwd_r = 0; dbe_r = 0; dwe_r = 0;
    for (int c = 0; c < 600; c++) begin
      if (!ireq_act) begin
        ireq_act = 1'($urandom_range(0, 1));
        iaddr_r  = $urandom & 32'hFFFF_FFFC;
      end
      if (!dreq_act) begin
        dreq_act = 1'($urandom_range(0, 1));
        daddr_r  = $urandom;
        dwd_r    = $urandom;
        dbe_r    = 4'($urandom);
        dwe_r    = 1'($urandom_range(0, 1));
      end
      r   = ($urandom_range(0, 24) != 0);
      mrd = $urandom;
      drive(r, ireq_act, iaddr_r, dreq_act, dwe_r, dbe_r, daddr_r, dwd_r, mrd);
      conf = ireq_act && dreq_act;
      m_ig = 1'b0; m_dg = 1'b0;
      if (r) begin
        if (conf) begin
          if (mcnt < MAXS) m_dg = 1'b1;
          else             m_ig = 1'b1;
        end else begin
          m_ig = ireq_act;
          m_dg = dreq_act;
        end
      end
      #4;
      check_outputs("rand", m_ig, m_dg, r && prev_owner == 1, r && prev_owner == 2);
      if (!r) begin
        mcnt = 0; prev_owner = 0;
      end else begin
        if (m_ig) mcnt = 0;
        else if (m_dg && conf && mcnt < MAXS) mcnt = mcnt + 1;
        prev_owner = m_ig ? 1 : (m_dg ? 2 : 0);
      end
      if (m_ig) ireq_act = 1'b0;
      if (m_dg) dreq_act = 1'b0;
      @(posedge clk); #1;
      chk("rand.starve_cnt", 32'(dut.starve_cnt), 32'(mcnt));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/miriscv_imem_arbiter.md
Name: miriscv_imem_arbiter

Overview:
Shares one single-port, fixed-latency unified memory between the instruction-fetch requester and the data requester (miriscv_lsu). Arbitrates each cycle and drives the memory port. Routes the read response back to whichever requester owns it. Data accesses have priority, and a starvation counter guarantees instruction fetch forward progress. Sits between the core's fetch/LSU ports and the program/data RAM.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MAX_STARVE, 3, consecutive conflicts data may win before fetch is forced through (1..15)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-low (0 = reset)
instr_req_i  in  1  fetch request
instr_addr_i  in  ADDR_W  fetch byte address
instr_gnt_o  out  1  fetch request accepted this cycle
instr_rvalid_o  out  1  fetch response valid
instr_rdata_o  out  DATA_W  fetch response data
data_req_i  in  1  data request
data_we_i  in  1  1 = write
data_be_i  in  DATA_W/8  byte enables
data_addr_i  in  ADDR_W  data byte address
data_wdata_i  in  DATA_W  write data
data_gnt_o  out  1  data request accepted this cycle
data_rvalid_o  out  1  data response valid (reads and writes)
data_rdata_o  out  DATA_W  read data
mem_req_o  out  1  memory access this cycle
mem_we_o  out  1  memory write enable
mem_be_o  out  DATA_W/8  memory byte enables
mem_addr_o  out  ADDR_W  memory byte address
mem_wdata_o  out  DATA_W  memory write data
mem_rdata_i  in  DATA_W  memory read data, valid exactly 1 cycle after mem_req_o

Behaviour:
- The memory always accepts requests. At most one grant per cycle. Grants are combinational in the request cycle.
- Arbitration when both requesters are active:
  - If starve_cnt < MAX_STARVE: the data requester wins and starve_cnt increments.
  - Otherwise: the fetch requester wins and starve_cnt clears to 0.
- With a single requester, that requester is granted. Any fetch grant clears starve_cnt. A data grant without a conflict leaves starve_cnt unchanged.
- Memory-port drive:
  - Fetch grant: mem_we_o=0, mem_be_o=all ones, mem_addr_o=instr_addr_i, mem_wdata_o=0.
  - Data grant: data_* fields pass through unchanged.
  - No grant: mem_req_o=0 and all other mem_* outputs are 0.
- Owner FSM records whose response is in flight:
  - States OWN_NONE, OWN_INSTR, OWN_DATA.
  - Next state = owner of this cycle's grant, or OWN_NONE if there is no grant.
- Response routing:
  - Fetch: instr_rvalid_o = (state==OWN_INSTR).
  - Data: data_rvalid_o = (state==OWN_DATA).
  - Read data: both *_rdata_o = mem_rdata_i when the matching rvalid is high, else 0.
  - Data writes also return data_rvalid_o; data_rdata_o is then mem_rdata_i and the LSU ignores it.
- Latency: request to rvalid is exactly 1 cycle. Back-to-back grants to the same or alternating requesters give one response per cycle with no bubbles.
- Reset (rst==0):
  - State registers: state=OWN_NONE, starve_cnt=0.
  - Outputs: all gnt, rvalid and mem_req outputs 0 during the reset cycle, all rdata outputs 0.
  - A response in flight when reset asserts is dropped. No rvalid appears in the first cycle after reset deasserts.
- starve_cnt width is clog2(MAX_STARVE+1) and it saturates at MAX_STARVE; it never wraps.
- Requesters must hold req/addr/data stable until granted. The block does not register requests.

Decomposition:
- Shared package miriscv_mem_pkg holds:
  - owner enum (OWN_NONE, OWN_INSTR, OWN_DATA)
  - BE_WORD constant (all ones)
  - default MAX_STARVE
- No sub-module is needed. The counter and FSM are small enough to live inline.

Test Plan:
- Reset then fetch-only: instr_req=1, addr=0x00,0x04,0x08 on consecutive cycles, mem_rdata = 0x13,0x93,0x113 -> gnt every cycle; instr_rvalid on cycles 1-3 with matching data; data_rvalid never asserts.
- Data write alone: we=1, be=4'b0011, addr=0x40, wdata=0xDEADBEEF -> mem_we=1, mem_be=0011, mem_addr=0x40; data_rvalid 1 cycle later.
- Conflict with MAX_STARVE=3, both req held:
  - Grants go data,data,data,instr,data,data,data,instr.
  - starve_cnt reads 1,2,3,0 in the cycles after each grant.
- Alternating grants: fetch granted at 0x10, data read at 0x80 in the next cycle -> instr_rvalid then data_rvalid on consecutive cycles, each with its own mem_rdata, never both high.
- Reset mid-flight: data read granted, rst=0 on the next edge -> no data_rvalid afterwards; state=OWN_NONE; starve_cnt=0; gnt and mem_req 0 while rst=0.
- Idle: no requests for 5 cycles -> mem_req_o=0 and mem_addr_o=0; no rvalid; starve_cnt unchanged.
